// File: rtl/mul_seq_ctrl_pkg.sv
// mul_seq_pkg
// Shared types for the sequential shift-add multiplier.
//   mul_state_t : controller state (IDLE -> CALC -> DONE -> IDLE)
//   cnt_width() : bits needed for a step counter that reaches WIDTH
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_add_nbit.sv
// add_nbit
// Plain WIDTH-bit ripple adder, the single arithmetic resource that the
// multiplier reuses on every step.
//   x, y : WIDTH-bit addends
//   cin  : carry in
//   sum  : low WIDTH bits of x + y + cin
//   cout : carry out
module add_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] total;

  assign total = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  assign sum   = total[WIDTH-1:0];
  assign cout  = total[WIDTH];

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
// Unsigned WIDTH x WIDTH sequential shift-add multiplier. One adder is
// reused for WIDTH steps; {acc, mq} is the running 2*WIDTH product register
// whose low half initially holds the multiplier.
//   clk, rst                  : clock, synchronous active-high reset
//   start_valid/start_ready/a/b : operand handshake (accepted only in IDLE)
//   busy                      : high in CALC or DONE
//   done_valid/done_ready     : result handshake, product held until taken
//   product                   : registered result, updated on entry to DONE
module mul_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done_valid,
  input  logic               done_ready,
  output logic [2*WIDTH-1:0] product
);

  import mul_seq_pkg::*;

  localparam int              CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  mul_state_t         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_y;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign add_y = mq_q[0] ? mcand_q : '0;

  add_nbit #(.WIDTH(WIDTH)) u_add (
    .x    (acc_q),
    .y    (add_y),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Shift {cout, sum, mq} right by one: the carry lands in the acc MSB
        // and the sum LSB moves into the top of mq as a finished product bit.
        acc_d = {add_cout, add_sum[WIDTH-1:1]};
        mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          product_d = {acc_d, mq_d};
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done_valid  = (state_q == DONE);
  assign product     = product_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Testbench for mul_seq_ctrl: scoreboard of expected products (plain a*b)
// pushed on each accepted start, popped by an independent monitor on each
// completed done handshake. A second WIDTH=8 instance covers the max case.
module tb_mul_seq_ctrl;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start_valid, start_ready, busy, done_valid, done_ready;
  logic [W-1:0]     a, b;
  logic [2*W-1:0]   product;

  logic             start_valid8, start_ready8, busy8, done_valid8, done_ready8;
  logic [W8-1:0]    a8, b8;
  logic [2*W8-1:0]  product8;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .busy(busy),
    .done_valid(done_valid), .done_ready(done_ready),
    .product(product)
  );

  mul_seq_ctrl #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst),
    .start_valid(start_valid8), .start_ready(start_ready8),
    .a(a8), .b(b8), .busy(busy8),
    .done_valid(done_valid8), .done_ready(done_ready8),
    .product(product8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  // Inputs change at posedge+1, so values seen at the negedge are the ones
  // the next rising edge will act on.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a done transfer happens at the next edge when valid & ready.
  always @(negedge clk) begin
    if (!rst && done_valid && done_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_product: got %0d expected none", product);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("sb_product", 32'(product), 32'(mon_exp));
      end
    end
  end

  // Random consumer backpressure, enabled only in the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) done_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
    int tries;
    int p;
    tries = 0;
    a = ia;
    b = ib;
    start_valid = 1'b1;
    while (!start_ready && tries < 200) begin
      step();
      tries++;
    end
    if (!start_ready) begin
      chk("accept_timeout", 32'(tries), 32'(0));
      start_valid = 1'b0;
      return;
    end
    p = int'(ia) * int'(ib);
    exp_q.push_back((2*W)'(p));
    step();
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_valid && n < 100) begin
      step();
      n++;
    end
    if (!done_valid) chk("done_timeout", 32'(done_valid), 32'(1));
  endtask

  int n;

  initial begin
    start_valid = 1'b0; a = '0; b = '0; done_ready = 1'b0;
    start_valid8 = 1'b0; a8 = '0; b8 = '0; done_ready8 = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_start_ready", 32'(start_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done_valid", 32'(done_valid), 32'(0));
    chk("rst_product", 32'(product), 32'(0));
    chk("rst_product8", 32'(product8), 32'(0));
    rst = 1'b0;
    step();

    // WIDTH=8 maximum operands
    a8 = 8'hFF; b8 = 8'hFF; start_valid8 = 1'b1; done_ready8 = 1'b1;
    step();
    start_valid8 = 1'b0;
    n = 0;
    while (!done_valid8 && n < 100) begin step(); n++; end
    chk("w8_latency", 32'(n), 32'(W8));
    chk("w8_max_product", 32'(product8), 32'h0000FE01);
    step();

    // Basic: 13*11 with latency and return to IDLE
    done_ready = 1'b1;
    issue(4'd13, 4'd11);
    wait_done(n);
    chk("latency_13x11", 32'(n), 32'(W));
    chk("product_13x11", 32'(product), 32'h8F);
    step();
    chk("idle_after_done", 32'(start_ready), 32'(1));
    chk("busy_after_done", 32'(busy), 32'(0));

    // Carry-out capture and zero operands
    issue(4'd15, 4'd15);
    wait_done(n);
    chk("product_15x15", 32'(product), 32'hE1);
    issue(4'd0, 4'd9);
    wait_done(n);
    chk("latency_0x9", 32'(n), 32'(W));
    chk("product_0x9", 32'(product), 32'(0));
    issue(4'd7, 4'd0);
    wait_done(n);
    chk("latency_7x0", 32'(n), 32'(W));
    chk("product_7x0", 32'(product), 32'(0));
    step();

    // Backpressure: hold DONE 10 cycles with start pulses
    done_ready = 1'b0;
    issue(4'd12, 4'd13);
    wait_done(n);
    for (int i = 0; i < 10; i++) begin
      start_valid = 1'(i % 2);
      a = W'($urandom);
      b = W'($urandom);
      step();
      chk("bp_done_valid", 32'(done_valid), 32'(1));
      chk("bp_product", 32'(product), 32'(156));
      chk("bp_start_ready", 32'(start_ready), 32'(0));
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    step();
    chk("bp_release_ready", 32'(start_ready), 32'(1));
    chk("bp_release_busy", 32'(busy), 32'(0));

    // New start during CALC is ignored
    issue(4'd6, 4'd5);
    a = 4'd9; b = 4'd9; start_valid = 1'b1;
    step();
    step();
    start_valid = 1'b0;
    wait_done(n);
    chk("product_6x5_ignore", 32'(product), 32'(30));
    step();

    // Reset two cycles after accept
    issue(4'd10, 4'd7);
    step();
    rst = 1'b1;
    void'(exp_q.pop_back());
    step();
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done_valid", 32'(done_valid), 32'(0));
    chk("midrst_product", 32'(product), 32'(0));
    chk("midrst_start_ready", 32'(start_ready), 32'(1));
    rst = 1'b0;
    issue(4'd3, 4'd4);
    wait_done(n);
    chk("latency_3x4", 32'(n), 32'(W));
    chk("product_3x4", 32'(product), 32'(12));
    step();

    // Random back-to-back stream with random done_ready
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      issue(W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_rdy = 1'b0;
    step();
    done_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin step(); n++; end
    repeat (10) step();
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    chk("final_idle", 32'(start_ready), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
